// File: rtl/sqrt_sum_pkg.sv
// Shared types and widths for the sum-of-square-roots controller.
package sqrt_sum_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int ARG_W  = 32;
    localparam int ROOT_W = 16;
    localparam int RES_W  = 32;
endpackage

// File: rtl/sqrt_sum_lane_tracker.sv
// Tracks which isqrt lanes still owe a result for the current batch and
// sums the roots that arrive on owed lanes each cycle.
module sqrt_sum_lane_tracker
    import sqrt_sum_pkg::*;
#(
    parameter int N_ISQRT = 2,
    parameter int SUM_W   = ROOT_W + $clog2(N_ISQRT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [N_ISQRT-1:0]        load_mask,
    input  logic                      wait_en,
    input  logic [N_ISQRT-1:0]        y_vld,
    input  logic [N_ISQRT*ROOT_W-1:0] y,
    output logic [SUM_W-1:0]          sum,
    output logic                      batch_done,
    output logic                      spurious
);
    logic [N_ISQRT-1:0] pending_q;
    logic [N_ISQRT-1:0] pending_d;
    logic [N_ISQRT-1:0] hit;

    always_comb begin
        hit       = y_vld & pending_q;
        pending_d = pending_q & ~hit;
        sum       = '0;
        for (int j = 0; j < N_ISQRT; j++) begin
            if (hit[j]) sum = sum + SUM_W'(y[j*ROOT_W +: ROOT_W]);
        end
        // Completion is judged on the post-clear mask so the last arrival ends the batch at once.
        batch_done = wait_en && (pending_d == '0);
        spurious   = wait_en && ((y_vld & ~pending_q) != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst)         pending_q <= '0;
        else if (load)    pending_q <= load_mask;
        else if (wait_en) pending_q <= pending_d;
    end
endmodule

// File: rtl/sqrt_sum_n_fsm.sv
// Sums isqrt(arg[i]) over N_ARGS arguments by issuing batches of N_ISQRT
// requests to external isqrt lanes and accumulating their roots.
module sqrt_sum_n_fsm
    import sqrt_sum_pkg::*;
#(
    parameter int N_ARGS  = 3,
    parameter int N_ISQRT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arg_vld,
    input  logic [N_ARGS*ARG_W-1:0]   args,
    output logic                      arg_rdy,
    output logic                      res_vld,
    output logic [RES_W-1:0]          res,
    output logic                      err,
    output logic [N_ISQRT-1:0]        isqrt_x_vld,
    output logic [N_ISQRT*ARG_W-1:0]  isqrt_x,
    input  logic [N_ISQRT-1:0]        isqrt_y_vld,
    input  logic [N_ISQRT*ROOT_W-1:0] isqrt_y
);
    localparam int B       = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
    localparam int ACC_W   = ROOT_W + $clog2(N_ARGS + 1);
    localparam int SUM_W   = ROOT_W + $clog2(N_ISQRT + 1);
    localparam int BATCH_W = (B > 1) ? $clog2(B) : 1;
    localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(B - 1);

    state_t                   state_q;
    logic [N_ARGS*ARG_W-1:0]  args_q;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [BATCH_W-1:0]       batch_q, issue_batch_d;
    logic [RES_W-1:0]         res_q;
    logic                     res_vld_q, err_q, arg_rdy_q;
    logic [N_ISQRT-1:0]       x_vld_q, x_vld_d;
    logic [N_ISQRT*ARG_W-1:0] x_q, x_d;
    logic [SUM_W-1:0]         lane_sum;
    logic                     batch_done, spurious;
    int                       k_idx;

    // Operands for the next ISSUE cycle: batch 0 straight from the input port, later batches from the register.
    always_comb begin
        issue_batch_d = (state_q == IDLE) ? '0 : batch_q + BATCH_W'(1);
        x_vld_d       = '0;
        x_d           = '0;
        k_idx         = 0;
        for (int j = 0; j < N_ISQRT; j++) begin
            k_idx = int'(issue_batch_d) * N_ISQRT + j;
            if (k_idx < N_ARGS) begin
                x_vld_d[j] = 1'b1;
                x_d[j*ARG_W +: ARG_W] = (state_q == IDLE) ? args[k_idx*ARG_W +: ARG_W]
                                                          : args_q[k_idx*ARG_W +: ARG_W];
            end
        end
        acc_d = acc_q + ACC_W'(lane_sum);
    end

    sqrt_sum_lane_tracker #(
        .N_ISQRT (N_ISQRT),
        .SUM_W   (SUM_W)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .load       (state_q == ISSUE),
        .load_mask  (x_vld_q),
        .wait_en    (state_q == WAIT),
        .y_vld      (isqrt_y_vld),
        .y          (isqrt_y),
        .sum        (lane_sum),
        .batch_done (batch_done),
        .spurious   (spurious)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            arg_rdy_q <= 1'b1;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            err_q     <= 1'b0;
            acc_q     <= '0;
            batch_q   <= '0;
            x_vld_q   <= '0;
            x_q       <= '0;
        end else begin
            res_vld_q <= 1'b0;
            x_vld_q   <= '0;
            x_q       <= '0;
            case (state_q)
                IDLE: begin
                    if (arg_vld) begin
                        args_q    <= args;
                        acc_q     <= '0;
                        batch_q   <= '0;
                        x_vld_q   <= x_vld_d;
                        x_q       <= x_d;
                        arg_rdy_q <= 1'b0;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    acc_q <= acc_d;
                    if (spurious) err_q <= 1'b1;
                    if (batch_done) begin
                        if (batch_q == LAST_BATCH) begin
                            res_q     <= RES_W'(acc_d);
                            res_vld_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            batch_q <= issue_batch_d;
                            x_vld_q <= x_vld_d;
                            x_q     <= x_d;
                            state_q <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    arg_rdy_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arg_rdy     = arg_rdy_q;
    assign res_vld     = res_vld_q;
    assign res         = res_q;
    assign err         = err_q;
    assign isqrt_x_vld = x_vld_q;
    assign isqrt_x     = x_q;
endmodule

// File: tb/tb_sqrt_sum_n_fsm.sv
// Bench for sqrt_sum_n_fsm: a default (3 args, 2 lanes) instance and a 4x4 instance
// driven by a latency-configurable isqrt model and checked through scoreboards.
module tb_sqrt_sum_n_fsm;
    localparam int NL = 6;  // lanes 0..1 belong to u_a, lanes 2..5 to u_b

    typedef struct {
        logic [31:0] res;
        int          cyc;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         a_vld, a_rdy, a_res_vld, a_err;
    logic [95:0]  a_args;
    logic [31:0]  a_res;
    logic [1:0]   a_x_vld;
    logic [63:0]  a_x;
    logic         b_vld, b_rdy, b_res_vld, b_err;
    logic [127:0] b_args;
    logic [31:0]  b_res;
    logic [3:0]   b_x_vld;
    logic [127:0] b_x;

    logic [NL-1:0]    x_vld_all;
    logic [NL*32-1:0] x_all;
    logic [NL-1:0]    y_vld_all = '0;
    logic [NL*16-1:0] y_all = '0;
    logic [NL-1:0]    inj_vld;
    logic [15:0]      inj_y;

    assign x_vld_all = {b_x_vld, a_x_vld};
    assign x_all     = {b_x, a_x};

    sqrt_sum_n_fsm #(.N_ARGS(3), .N_ISQRT(2)) u_a (
        .clk(clk), .rst(rst), .arg_vld(a_vld), .args(a_args), .arg_rdy(a_rdy),
        .res_vld(a_res_vld), .res(a_res), .err(a_err),
        .isqrt_x_vld(a_x_vld), .isqrt_x(a_x),
        .isqrt_y_vld(y_vld_all[1:0]), .isqrt_y(y_all[31:0])
    );

    sqrt_sum_n_fsm #(.N_ARGS(4), .N_ISQRT(4)) u_b (
        .clk(clk), .rst(rst), .arg_vld(b_vld), .args(b_args), .arg_rdy(b_rdy),
        .res_vld(b_res_vld), .res(b_res), .err(b_err),
        .isqrt_x_vld(b_x_vld), .isqrt_x(b_x),
        .isqrt_y_vld(y_vld_all[5:2]), .isqrt_y(y_all[95:32])
    );

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          lat [NL];
    int          due_q [NL][$];
    logic [15:0] val_q [NL][$];
    exp_t        sb_a[$];
    exp_t        sb_b[$];
    exp_t        ea, eb;
    logic [127:0] v;
    bit          found;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Root by bisection, used by the isqrt lane model.
    function automatic logic [15:0] isqrt_bits(input logic [31:0] x);
        logic [31:0] lo, hi, mid;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (64'(mid) * 64'(mid) <= 64'(x)) lo = mid;
            else hi = mid - 1;
        end
        return lo[15:0];
    endfunction

    // Reference: floating-point root, summed over the argument vector.
    function automatic logic [31:0] ref_sum(input logic [127:0] vec, input int n);
        logic [31:0] s;
        real         r;
        s = 0;
        for (int i = 0; i < n; i++) begin
            r = $floor($sqrt(real'(vec[i*32 +: 32])));
            s = s + 32'(int'(r));
        end
        return s;
    endfunction

    // Reference latency: one cycle to issue, then each batch costs its slowest lane plus one.
    function automatic int ref_cycles(input int n, input int nisq, input int base);
        int c, m;
        c = 1;
        for (int b = 0; b * nisq < n; b++) begin
            m = 0;
            for (int j = 0; j < nisq && b * nisq + j < n; j++)
                if (lat[base + j] > m) m = lat[base + j];
            c = c + m + 1;
        end
        return c;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return $urandom_range(0, 1000);
            2: return 32'hFFFF_FFFF - $urandom_range(0, 3);
            default: begin
                r = $urandom_range(0, 65535);
                return r * r - $urandom_range(0, 1);
            end
        endcase
    endfunction

    task automatic issue(input bit on_b, input logic [127:0] vec, input logic exp_err, input int hold);
        exp_t e;
        @(posedge clk); #1;
        e.err = exp_err;
        if (on_b) begin
            check("b_rdy_idle", b_rdy, 1);
            b_args = vec;
            b_vld  = 1'b1;
            e.res  = ref_sum(vec, 4);
            e.cyc  = cyc + ref_cycles(4, 4, 2);
            sb_b.push_back(e);
        end else begin
            check("a_rdy_idle", a_rdy, 1);
            a_args = vec[95:0];
            a_vld  = 1'b1;
            e.res  = ref_sum(vec, 3);
            e.cyc  = cyc + ref_cycles(3, 2, 0);
            sb_a.push_back(e);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (on_b) begin
                check("b_rdy_busy", b_rdy, 0);
                b_args = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                check("a_rdy_busy", a_rdy, 0);
                a_args = {$urandom, $urandom, $urandom};
            end
        end
        @(posedge clk); #1;
        a_vld = 1'b0;
        b_vld = 1'b0;
    endtask

    task automatic drain(input bit on_b);
        int n;
        n = 0;
        while (((on_b ? sb_b.size() : sb_a.size()) != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check(on_b ? "b_drain_timeout" : "a_drain_timeout", 1, 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_res_a(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (a_res_vld === 1'b1) seen = 1'b1;
        end
        if (!seen) check("a_res_timeout", 1, 0);
    endtask

    initial begin
        rst = 1'b0;
        a_vld = 1'b0; a_args = '0;
        b_vld = 1'b0; b_args = '0;
        inj_vld = '0; inj_y = '0;
        for (int j = 0; j < NL; j++) lat[j] = 1;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            // isqrt lane model: root returned lat[j] cycles after the request cycle.
            forever begin
                @(posedge clk); #1;
                for (int j = 0; j < NL; j++) begin
                    y_vld_all[j]       = inj_vld[j];
                    y_all[j*16 +: 16]  = inj_vld[j] ? inj_y : 16'($urandom);
                    if (due_q[j].size() != 0 && due_q[j][0] == cyc) begin
                        y_vld_all[j]      = 1'b1;
                        y_all[j*16 +: 16] = val_q[j].pop_front();
                        void'(due_q[j].pop_front());
                    end
                end
                @(negedge clk);
                for (int j = 0; j < NL; j++) begin
                    if (x_vld_all[j] === 1'b1) begin
                        due_q[j].push_back(cyc + lat[j]);
                        val_q[j].push_back(isqrt_bits(x_all[j*32 +: 32]));
                    end
                end
            end
            forever begin
                @(negedge clk);
                if (a_res_vld === 1'b1) begin
                    if (sb_a.size() == 0) check("a_unexpected_res", 1, 0);
                    else begin
                        ea = sb_a.pop_front();
                        check("a_res", a_res, ea.res);
                        check("a_res_cycle", cyc, ea.cyc);
                        check("a_err_at_res", a_err, ea.err);
                    end
                end
                if (b_res_vld === 1'b1) begin
                    if (sb_b.size() == 0) check("b_unexpected_res", 1, 0);
                    else begin
                        eb = sb_b.pop_front();
                        check("b_res", b_res, eb.res);
                        check("b_res_cycle", cyc, eb.cyc);
                        check("b_err_at_res", b_err, eb.err);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk); #1;
        check("rst_a_res", a_res, 0);
        check("rst_a_res_vld", a_res_vld, 0);
        check("rst_a_err", a_err, 0);
        check("rst_a_rdy", a_rdy, 1);
        check("rst_a_x_vld", a_x_vld, 0);
        check("rst_b_res", b_res, 0);
        check("rst_b_err", b_err, 0);
        check("rst_b_rdy", b_rdy, 1);
        check("rst_b_x_vld", b_x_vld, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Basic sum, then all-ones operands.
        issue(1'b0, {32'd0, 32'd36, 32'd25, 32'd16}, 1'b0, 0);
        drain(1'b0);
        #1 check("a_res_held", a_res, 15);
        issue(1'b0, {32'd0, {3{32'hFFFF_FFFF}}}, 1'b0, 0);
        drain(1'b0);

        // Skewed lane latencies.
        lat[0] = 1; lat[1] = 4;
        issue(1'b0, {32'd0, 32'd9, 32'd49, 32'd100}, 1'b0, 0);
        drain(1'b0);

        // arg_vld held through a computation with changing data.
        lat[0] = 1; lat[1] = 1;
        issue(1'b0, {32'd0, pick(), pick(), pick()}, 1'b0, 5);
        drain(1'b0);

        // Random vectors and latencies; odd iterations start back-to-back after DONE.
        for (int it = 0; it < 16; it++) begin
            lat[0] = $urandom_range(1, 4);
            lat[1] = $urandom_range(1, 4);
            v = {32'd0, pick(), pick(), pick()};
            issue(1'b0, v, 1'b0, 0);
            if (it % 2 == 1) drain(1'b0);
            else wait_res_a(found);
        end
        drain(1'b0);

        // Reset during WAIT aborts the job; late roots land in IDLE.
        lat[0] = 3; lat[1] = 3;
        issue(1'b0, {32'd0, 32'd9, 32'd8, 32'd7}, 1'b0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb_a.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        check("abort_res_cleared", a_res, 0);
        check("abort_err_cleared", a_err, 0);
        check("abort_rdy", a_rdy, 1);
        repeat (2) @(posedge clk); #1;
        check("late_y_no_err", a_err, 0);
        lat[0] = 1; lat[1] = 1;
        issue(1'b0, {32'd0, 32'd4, 32'd4, 32'd4}, 1'b0, 0);
        drain(1'b0);

        // Wide instance: random jobs, then a spurious root on lane 2 during WAIT.
        for (int it = 0; it < 6; it++) begin
            for (int j = 2; j < 6; j++) lat[j] = $urandom_range(1, 4);
            issue(1'b1, {pick(), pick(), pick(), pick()}, 1'b0, 0);
            drain(1'b1);
        end
        lat[2] = 1; lat[3] = 1; lat[4] = 1; lat[5] = 3;
        issue(1'b1, {32'd16, 32'd9, 32'd4, 32'd1}, 1'b1, 0);
        @(posedge clk);
        @(negedge clk);
        inj_vld[4] = 1'b1;
        inj_y      = 16'd1000;
        @(negedge clk);
        inj_vld = '0;
        drain(1'b1);
        #1 check("b_err_sticky", b_err, 1);
        check("a_err_isolated", a_err, 0);
        lat[2] = 2; lat[3] = 1; lat[4] = 4; lat[5] = 1;
        issue(1'b1, {pick(), pick(), pick(), pick()}, 1'b1, 0);
        drain(1'b1);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
